// File: rtl/btn_io_pkg.sv
// Shared constants for the button event port: event codes and default parameters.
package btn_io_pkg;

  typedef enum logic [2:0] {
    EVT_NONE = 3'd0,
    EVT_U    = 3'd1,
    EVT_D    = 3'd2,
    EVT_L    = 3'd3,
    EVT_R    = 3'd4
  } evt_code_e;

  localparam int unsigned  DEBOUNCE_CYCLES_DEF = 250000;
  localparam int unsigned  CNT_W_DEF           = 18;
  localparam int unsigned  DEPTH_DEF           = 4;
  localparam logic [31:0]  IO_ADDR_DEF         = 32'd4096;

  // Button index 0..3 is U, D, L, R; a lower index is a lower code.
  function automatic evt_code_e btn_code(input logic [1:0] idx);
    case (idx)
      2'd0:    return EVT_U;
      2'd1:    return EVT_D;
      2'd2:    return EVT_L;
      default: return EVT_R;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stability counter, debounced level and a
// single-cycle pulse on an accepted 0->1 transition.
module btn_debounce
  import btn_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic rise
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise     = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise     = sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/btn_event_port.sv
// Memory-mapped button event port: debounced press events queue in a small FIFO
// and are popped one per load from IO_ADDR; other addresses pass RAM data through.
module btn_event_port
  import btn_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned DEPTH           = DEPTH_DEF,
  parameter logic [31:0] IO_ADDR         = IO_ADDR_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic [31:0] mem_addr,
  input  logic        mem_wren,
  input  logic [31:0] ram_rdata,
  output logic [31:0] q_dmem,
  output logic [2:0]  evt_count,
  output logic        overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [3:0] btn_raw;
  logic [3:0] rise;

  assign btn_raw = {btn_r, btn_l, btn_d, btn_u};

  for (genvar b = 0; b < 4; b++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clock   (clock),
      .reset_n (reset_n),
      .btn_raw (btn_raw[b]),
      .rise    (rise[b])
    );
  end

  logic [3:0]       pend_q, pend_d;
  logic [2:0]       mem_q [DEPTH];
  logic [2:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       snap_q, snap_d;
  logic             hit_q, hit_d;

  logic       rd_hit, wr_hit;
  logic       sel_vld;
  logic [1:0] sel_idx;
  logic [3:0] sel_oh;
  logic       fifo_full, fifo_empty;
  logic       pop, push_ok, drop;
  logic [2:0] head;

  assign rd_hit     = (mem_addr == IO_ADDR) & ~mem_wren;
  assign wr_hit     = (mem_addr == IO_ADDR) &  mem_wren;
  assign fifo_empty = (cnt_q == 3'd0);
  assign fifo_full  = (cnt_q == 3'(DEPTH));
  assign head       = fifo_empty ? 3'(EVT_NONE) : mem_q[rd_ptr_q];

  // Lowest pending index wins; scanning downward leaves the lowest one selected.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_vld = 1'b1;
        sel_idx = 2'(i);
      end
    end
    sel_oh = sel_vld ? (4'b0001 << sel_idx) : 4'b0000;
  end

  assign pop     = rd_hit & ~hit_q & ~fifo_empty;
  assign push_ok = sel_vld & ~wr_hit & (~fifo_full | pop);
  assign drop    = sel_vld & ~wr_hit & fifo_full & ~pop;

  always_comb begin
    pend_d   = (pend_q & ~sel_oh) | rise;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    snap_d   = snap_q;
    hit_d    = rd_hit;

    if (rd_hit && !hit_q) begin
      snap_d = head;
    end

    if (wr_hit) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = 3'd0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = 3'(btn_code(sel_idx));
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + {2'b00, push_ok} - {2'b00, pop};
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= 3'd0;
      ovf_q    <= 1'b0;
      snap_q   <= 3'd0;
      hit_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 3'd0;
      end
    end else begin
      pend_q   <= pend_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      snap_q   <= snap_d;
      hit_q    <= hit_d;
      mem_q    <= mem_d;
    end
  end

  // A stalled load keeps returning the snapshot taken on its first cycle.
  always_comb begin
    if (rd_hit) begin
      q_dmem = hit_q ? {29'b0, snap_q} : {29'b0, head};
    end else begin
      q_dmem = ram_rdata;
    end
  end

  assign evt_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_btn_event_port.sv
// Directed bench for btn_event_port with a short debounce window.
module tb_btn_event_port;

  localparam logic [31:0] IO   = 32'd4096;
  localparam logic [31:0] IDLE = 32'd0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic [31:0] mem_addr = IDLE;
  logic        mem_wren = 1'b0;
  logic [31:0] ram_rdata = 32'h1234_5678;
  logic [31:0] q_dmem;
  logic [2:0]  evt_count;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  btn_event_port #(
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (4),
    .DEPTH           (4),
    .IO_ADDR         (32'd4096)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .btn_u     (btn_u),
    .btn_d     (btn_d),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .mem_addr  (mem_addr),
    .mem_wren  (mem_wren),
    .ram_rdata (ram_rdata),
    .q_dmem    (q_dmem),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // mask bit order: {r, l, d, u}
  task automatic set_btn(input logic [3:0] m);
    @(negedge clock);
    {btn_r, btn_l, btn_d, btn_u} = m;
  endtask

  task automatic press(input logic [3:0] m);
    set_btn(m);
    wait_cyc(15);
    set_btn(4'b0000);
    wait_cyc(15);
  endtask

  // One-cycle load from the port; idle long enough for hit_q to drop.
  task automatic do_read(input string tag, input logic [31:0] exp);
    @(negedge clock);
    mem_addr = IO;
    mem_wren = 1'b0;
    #1 check_eq(tag, q_dmem, exp);
    @(negedge clock);
    mem_addr = IDLE;
    @(negedge clock);
  endtask

  initial begin
    wait_cyc(3);
    #1 check_eq("rst_count", 32'(evt_count), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_pass", q_dmem, 32'h1234_5678);
    @(negedge clock);
    reset_n = 1'b1;

    // 1: long press of U
    set_btn(4'b0001);
    wait_cyc(20);
    check_eq("t1_count1", 32'(evt_count), 32'd1);
    do_read("t1_read_u", 32'd1);
    check_eq("t1_count0", 32'(evt_count), 32'd0);
    set_btn(4'b0000);
    wait_cyc(20);
    check_eq("t1_release", 32'(evt_count), 32'd0);
    do_read("t1_read_empty", 32'd0);

    // 2: glitch on D shorter than the debounce window
    set_btn(4'b0010);
    wait_cyc(5);
    set_btn(4'b0000);
    wait_cyc(20);
    check_eq("t2_glitch", 32'(evt_count), 32'd0);

    // 3: U and R together enqueue U first
    set_btn(4'b1001);
    wait_cyc(20);
    check_eq("t3_count", 32'(evt_count), 32'd2);
    do_read("t3_read_u", 32'd1);
    do_read("t3_read_r", 32'd4);
    set_btn(4'b0000);
    wait_cyc(20);

    // 4: five presses overflow a four-entry queue
    press(4'b0001);
    press(4'b0010);
    press(4'b0100);
    press(4'b1000);
    press(4'b0010);
    check_eq("t4_count", 32'(evt_count), 32'd4);
    check_eq("t4_ovf", 32'(overflow), 32'd1);
    do_read("t4_read0", 32'd1);
    do_read("t4_read1", 32'd2);
    do_read("t4_read2", 32'd3);
    do_read("t4_read3", 32'd4);
    check_eq("t4_drained", 32'(evt_count), 32'd0);
    check_eq("t4_ovf_kept", 32'(overflow), 32'd1);
    press(4'b0100);
    @(negedge clock);
    mem_addr = IO;
    mem_wren = 1'b1;
    @(negedge clock);
    mem_addr = IDLE;
    mem_wren = 1'b0;
    #1 check_eq("t4_ovf_clr", 32'(overflow), 32'd0);
    check_eq("t4_flush", 32'(evt_count), 32'd0);

    // 5: stalled load pops exactly one event
    press(4'b0100);
    press(4'b0010);
    check_eq("t5_count2", 32'(evt_count), 32'd2);
    @(negedge clock);
    mem_addr = IO;
    #1 check_eq("t5_hold0", q_dmem, 32'd3);
    @(negedge clock);
    #1 check_eq("t5_hold1", q_dmem, 32'd3);
    check_eq("t5_cnt_hold1", 32'(evt_count), 32'd1);
    @(negedge clock);
    #1 check_eq("t5_hold2", q_dmem, 32'd3);
    check_eq("t5_cnt_hold2", 32'(evt_count), 32'd1);
    @(negedge clock);
    mem_addr = IDLE;
    @(negedge clock);
    check_eq("t5_cnt_after", 32'(evt_count), 32'd1);
    do_read("t5_read_d", 32'd2);

    // 6: pass-through, then reset mid-debounce
    @(negedge clock);
    mem_addr  = 32'd100;
    ram_rdata = 32'hDEAD_BEEF;
    #1 check_eq("t6_pass", q_dmem, 32'hDEAD_BEEF);
    mem_addr = IDLE;
    press(4'b0001);
    set_btn(4'b1000);
    wait_cyc(4);
    reset_n = 1'b0;
    #1 check_eq("t6_rst_count", 32'(evt_count), 32'd0);
    mem_addr = IO;
    #1 check_eq("t6_rst_q", q_dmem, 32'd0);
    mem_addr = IDLE;
    set_btn(4'b0000);
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(20);
    check_eq("t6_no_evt", 32'(evt_count), 32'd0);
    check_eq("t6_ovf", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
